// File: rtl/wishbone_bus_arbiter_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wishbone_bus_arbiter_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    // Encoding doubles as the one-hot {lsu,if} grant vector.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_IF   = 2'b01,
        ARB_LSU  = 2'b10
    } arb_state_t;

    // Map the grant state to the externally visible one-hot owner vector.
    function automatic logic [1:0] grant_of(input arb_state_t state);
        logic [1:0] grant;
        case (state)
            ARB_IF:  grant = 2'b01;
            ARB_LSU: grant = 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/wishbone_bus_arbiter_watchdog.sv
// No-ack watchdog: counts strobe cycles without a slave response and
// produces a one-cycle expiry pulse when the limit is reached.
module wb_watchdog
    import wishbone_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic stb,
    input  logic ack,
    input  logic err,
    input  logic bus_release,
    output logic expire,
    output logic expire_last
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wd
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

            logic [CNT_W-1:0] cnt_r;
            logic [CNT_W-1:0] cnt_nxt_s;
            logic             expire_s;
            logic             expire_last_r;

            // Expiry fires only if no response arrives this cycle: a coincident ack wins.
            always_comb begin
                expire_s = 1'b0;
                if (stb && !ack && !err && (cnt_r == LIMIT)) begin
                    expire_s = 1'b1;
                end else begin
                    expire_s = 1'b0;
                end
            end

            // Count unanswered strobe cycles, clear on any response, release or expiry, saturate at the limit.
            always_comb begin
                cnt_nxt_s = cnt_r;
                if (bus_release || !stb || ack || err || expire_s) begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end else if (cnt_r != LIMIT) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end

            // Counter and the one-cycle memory of an expiry used to drop a late ack.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_r         <= {CNT_W{1'b0}};
                    expire_last_r <= 1'b0;
                end else begin
                    cnt_r         <= cnt_nxt_s;
                    expire_last_r <= expire_s;
                end
            end

            assign expire      = expire_s;
            assign expire_last = expire_last_r;
        end else begin : g_off
            assign expire      = 1'b0;
            assign expire_last = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/wishbone_bus_arbiter.sv
// Two-master (IF, LSU) Wishbone B4 classic arbiter with registered grant,
// round-robin tie-break, whole-cycle locking and a no-ack watchdog.
module wishbone_bus_arbiter
    import wishbone_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter bit          LSU_FIRST      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_cyc_i,
    input  logic                 if_stb_i,
    input  logic                 if_we_i,
    input  logic [WB_ADDR_W-1:0] if_adr_i,
    input  logic [WB_DATA_W-1:0] if_dat_i,
    input  logic [WB_SEL_W-1:0]  if_sel_i,
    output logic [WB_DATA_W-1:0] if_dat_o,
    output logic                 if_ack_o,
    output logic                 if_err_o,
    input  logic                 lsu_cyc_i,
    input  logic                 lsu_stb_i,
    input  logic                 lsu_we_i,
    input  logic [WB_ADDR_W-1:0] lsu_adr_i,
    input  logic [WB_DATA_W-1:0] lsu_dat_i,
    input  logic [WB_SEL_W-1:0]  lsu_sel_i,
    output logic [WB_DATA_W-1:0] lsu_dat_o,
    output logic                 lsu_ack_o,
    output logic                 lsu_err_o,
    output logic                 mem_cyc_o,
    output logic                 mem_stb_o,
    output logic                 mem_we_o,
    output logic [WB_ADDR_W-1:0] mem_adr_o,
    output logic [WB_DATA_W-1:0] mem_dat_o,
    output logic [WB_SEL_W-1:0]  mem_sel_o,
    input  logic [WB_DATA_W-1:0] mem_dat_i,
    input  logic                 mem_ack_i,
    input  logic                 mem_err_i,
    output logic [1:0]           o_grant
);

    arb_state_t state_r;
    arb_state_t state_nxt_s;
    logic       last_lsu_r;       // 1: most recent grant went to LSU
    logic       last_lsu_nxt_s;
    logic       arbitrate_s;
    logic       if_req_s;
    logic       lsu_req_s;
    logic       owner_cyc_s;
    logic       owner_stb_s;
    logic       release_s;
    logic       expire_s;
    logic       expire_last_s;
    logic       drop_ack_s;

    assign if_req_s  = if_cyc_i & if_stb_i;
    assign lsu_req_s = lsu_cyc_i & lsu_stb_i;

    // Grant state and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ARB_IDLE;
            last_lsu_r <= (LSU_FIRST == 1'b1) ? 1'b0 : 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            last_lsu_r <= last_lsu_nxt_s;
        end
    end

    // Next grant: arbitrate when idle or when the owner drops CYC; otherwise the owner keeps the bus.
    always_comb begin
        state_nxt_s    = state_r;
        last_lsu_nxt_s = last_lsu_r;
        arbitrate_s    = 1'b0;
        case (state_r)
            ARB_IDLE: arbitrate_s = 1'b1;
            ARB_IF:   arbitrate_s = ~if_cyc_i;
            ARB_LSU:  arbitrate_s = ~lsu_cyc_i;
            default:  arbitrate_s = 1'b1;
        endcase
        if (arbitrate_s) begin
            if (if_req_s && lsu_req_s) begin
                state_nxt_s = last_lsu_r ? ARB_IF : ARB_LSU;
            end else if (if_req_s) begin
                state_nxt_s = ARB_IF;
            end else if (lsu_req_s) begin
                state_nxt_s = ARB_LSU;
            end else begin
                state_nxt_s = ARB_IDLE;
            end
            if (state_nxt_s == ARB_IF) begin
                last_lsu_nxt_s = 1'b0;
            end else if (state_nxt_s == ARB_LSU) begin
                last_lsu_nxt_s = 1'b1;
            end else begin
                last_lsu_nxt_s = last_lsu_r;
            end
        end else begin
            state_nxt_s    = state_r;
            last_lsu_nxt_s = last_lsu_r;
        end
    end

    // Request path mux: forward the owner's cycle signals to the slave, all zero when idle.
    always_comb begin
        owner_cyc_s = 1'b0;
        owner_stb_s = 1'b0;
        mem_we_o    = 1'b0;
        mem_adr_o   = {WB_ADDR_W{1'b0}};
        mem_dat_o   = {WB_DATA_W{1'b0}};
        mem_sel_o   = {WB_SEL_W{1'b0}};
        case (state_r)
            ARB_IF: begin
                owner_cyc_s = if_cyc_i;
                owner_stb_s = if_stb_i;
                mem_we_o    = if_we_i;
                mem_adr_o   = if_adr_i;
                mem_dat_o   = if_dat_i;
                mem_sel_o   = if_sel_i;
            end
            ARB_LSU: begin
                owner_cyc_s = lsu_cyc_i;
                owner_stb_s = lsu_stb_i;
                mem_we_o    = lsu_we_i;
                mem_adr_o   = lsu_adr_i;
                mem_dat_o   = lsu_dat_i;
                mem_sel_o   = lsu_sel_i;
            end
            default: begin
                owner_cyc_s = 1'b0;
            end
        endcase
    end

    assign release_s  = ~owner_cyc_s;
    assign mem_cyc_o  = owner_cyc_s;
    assign mem_stb_o  = owner_stb_s & ~expire_s;
    // An ack arriving just after expiry belongs to the abandoned strobe unless a new one is up.
    assign drop_ack_s = expire_last_s & ~owner_stb_s;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk         (clk),
        .reset       (reset),
        .stb         (owner_stb_s),
        .ack         (mem_ack_i),
        .err         (mem_err_i),
        .bus_release (release_s),
        .expire      (expire_s),
        .expire_last (expire_last_s)
    );

    // Response routing: only the owner sees ack/err; watchdog expiry appears as an error.
    always_comb begin
        if_ack_o  = 1'b0;
        if_err_o  = 1'b0;
        lsu_ack_o = 1'b0;
        lsu_err_o = 1'b0;
        case (state_r)
            ARB_IF: begin
                if_ack_o = mem_ack_i & ~drop_ack_s;
                if_err_o = mem_err_i | expire_s;
            end
            ARB_LSU: begin
                lsu_ack_o = mem_ack_i & ~drop_ack_s;
                lsu_err_o = mem_err_i | expire_s;
            end
            default: begin
                if_ack_o  = 1'b0;
                lsu_ack_o = 1'b0;
            end
        endcase
    end

    assign if_dat_o  = mem_dat_i;
    assign lsu_dat_o = mem_dat_i;
    assign o_grant   = grant_of(state_r);

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Self-checking bench: two master agents driven from job queues, a slave
// model with programmable latency, and a per-master response scoreboard.
module tb_wishbone_bus_arbiter;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdat;
        int          beats;
        logic        expect_err;
    } job_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        logic        we;
        logic        err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic [3:0]  m_sel [2];
    logic [31:0] if_dat_o, lsu_dat_o;
    logic        if_ack_o, if_err_o, lsu_ack_o, lsu_err_o;
    logic        mem_cyc_o, mem_stb_o, mem_we_o;
    logic [31:0] mem_adr_o, mem_dat_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_dat_i;
    logic        mem_ack_i, mem_err_i;
    logic [1:0]  o_grant;

    job_t        jobq[2][$];
    exp_t        expq[2][$];
    logic        busy[2];
    logic        abort_req[2];
    logic [1:0]  glog[$];
    int          slave_delay;
    logic        slave_mute;
    int          vectors;
    int          miscompares;

    wishbone_bus_arbiter #(
        .TIMEOUT_CYCLES(8),
        .LSU_FIRST     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_cyc_i  (m_cyc[0]),
        .if_stb_i  (m_stb[0]),
        .if_we_i   (m_we[0]),
        .if_adr_i  (m_adr[0]),
        .if_dat_i  (m_wdat[0]),
        .if_sel_i  (m_sel[0]),
        .if_dat_o  (if_dat_o),
        .if_ack_o  (if_ack_o),
        .if_err_o  (if_err_o),
        .lsu_cyc_i (m_cyc[1]),
        .lsu_stb_i (m_stb[1]),
        .lsu_we_i  (m_we[1]),
        .lsu_adr_i (m_adr[1]),
        .lsu_dat_i (m_wdat[1]),
        .lsu_sel_i (m_sel[1]),
        .lsu_dat_o (lsu_dat_o),
        .lsu_ack_o (lsu_ack_o),
        .lsu_err_o (lsu_err_o),
        .mem_cyc_o (mem_cyc_o),
        .mem_stb_o (mem_stb_o),
        .mem_we_o  (mem_we_o),
        .mem_adr_o (mem_adr_o),
        .mem_dat_o (mem_dat_o),
        .mem_sel_o (mem_sel_o),
        .mem_dat_i (mem_dat_i),
        .mem_ack_i (mem_ack_i),
        .mem_err_i (mem_err_i),
        .o_grant   (o_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] slave_data(input logic [31:0] adr);
        if (adr == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {adr[15:0], ~adr[15:0]};
    endfunction

    function automatic logic ack_of(input int m);
        return (m == 0) ? if_ack_o : lsu_ack_o;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? if_err_o : lsu_err_o;
    endfunction

    function automatic logic [31:0] dat_of(input int m);
        return (m == 0) ? if_dat_o : lsu_dat_o;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input int m, input logic [31:0] adr, input logic we,
                            input logic [31:0] wdat, input int beats, input logic expect_err);
        job_t j;
        j.adr = adr; j.we = we; j.wdat = wdat; j.beats = beats; j.expect_err = expect_err;
        jobq[m].push_back(j);
    endtask

    task automatic drive_beat(input int m, input job_t j, input int beat);
        exp_t e;
        m_cyc[m]  = 1'b1;
        m_stb[m]  = 1'b1;
        m_we[m]   = j.we;
        m_adr[m]  = j.adr + 32'(beat * 4);
        m_wdat[m] = j.wdat + 32'(beat);
        m_sel[m]  = 4'hF;
        e.adr  = m_adr[m];
        e.we   = j.we;
        e.data = j.we ? m_wdat[m] : slave_data(m_adr[m]);
        e.err  = j.expect_err;
        expq[m].push_back(e);
    endtask

    task automatic idle_bus(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
        m_we[m]  = 1'b0;
    endtask

    // Master agent: one job at a time, holds CYC across its beats, drops CYC for a cycle after the last response.
    task automatic agent(input int m);
        job_t j;
        int   beat;
        logic active;
        logic ack_seen;
        logic err_seen;
        active = 1'b0;
        beat   = 0;
        forever begin
            @(negedge clk);
            ack_seen = ack_of(m);
            err_seen = err_of(m);
            @(posedge clk);
            #1;
            if (abort_req[m]) begin
                idle_bus(m);
                active       = 1'b0;
                abort_req[m] = 1'b0;
            end else if (active) begin
                if (err_seen) begin
                    idle_bus(m);
                    active = 1'b0;
                end else if (ack_seen) begin
                    beat++;
                    if (beat >= j.beats) begin
                        idle_bus(m);
                        active = 1'b0;
                    end else begin
                        drive_beat(m, j, beat);
                    end
                end
            end else if (jobq[m].size() > 0) begin
                j      = jobq[m].pop_front();
                beat   = 0;
                active = 1'b1;
                drive_beat(m, j, 0);
            end
            busy[m] = active;
        end
    endtask

    initial agent(0);
    initial agent(1);

    // Slave model: acks after slave_delay wait cycles of a live strobe, never when muted.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        mem_dat_i = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_cyc_o && mem_stb_o && !slave_mute) begin
                if (wcnt >= slave_delay) begin
                    mem_ack_i = 1'b1;
                    mem_dat_i = slave_data(mem_adr_o);
                    wcnt      = 0;
                end else begin
                    mem_ack_i = 1'b0;
                    mem_dat_i = 32'h0;
                    wcnt++;
                end
            end else begin
                mem_ack_i = 1'b0;
                mem_dat_i = 32'h0;
                wcnt      = 0;
            end
        end
    end

    // Response monitor and grant-change log.
    initial begin
        logic [1:0] prev_grant;
        exp_t       e;
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (o_grant != prev_grant) begin
                glog.push_back(o_grant);
                prev_grant = o_grant;
            end
            for (int m = 0; m < 2; m++) begin
                if (ack_of(m) || err_of(m)) begin
                    if (expq[m].size() == 0) begin
                        check_value("unexpected_resp", 32'(expq[m].size()), 32'd1);
                    end else begin
                        e = expq[m].pop_front();
                        check_value("resp_owner", {30'b0, o_grant}, (m == 0) ? 32'd1 : 32'd2);
                        check_value("resp_adr", mem_adr_o, e.adr);
                        check_value("resp_err", {31'b0, err_of(m)}, {31'b0, e.err});
                        check_value("resp_ack", {31'b0, ack_of(m)}, {31'b0, ~e.err});
                        if (!e.err) begin
                            check_value("resp_data", e.we ? mem_dat_o : dat_of(m), e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((jobq[0].size() != 0 || jobq[1].size() != 0 || busy[0] || busy[1] ||
                o_grant != 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_value("idle_reached", {31'b0, (n < budget)}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Compare the grant-change log against n expected 2-bit entries packed LSB first.
    task automatic check_glog(input string tag, input logic [15:0] exp_seq, input int n);
        logic [15:0] seq;
        seq = exp_seq;
        check_value({tag, "_len"}, 32'(glog.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < glog.size()) begin
                check_value(tag, {30'b0, glog[i]}, {30'b0, seq[2*i +: 2]});
            end
        end
        glog.delete();
    endtask

    initial begin
        int   n;
        int   stb_cnt;
        logic found;
        vectors     = 0;
        miscompares = 0;
        slave_delay = 0;
        slave_mute  = 1'b0;
        reset       = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_adr[m] = 32'h0; m_wdat[m] = 32'h0; m_sel[m] = 4'h0;
            busy[m] = 1'b0; abort_req[m] = 1'b0;
        end

        // Reset with both masters requesting, then alternating single-beat reads.
        push_job(0, 32'h0000_0010, 1'b0, 32'h0, 1, 1'b0);
        push_job(0, 32'h0000_0014, 1'b0, 32'h0, 1, 1'b0);
        push_job(1, 32'h0000_0020, 1'b0, 32'h0, 1, 1'b0);
        push_job(1, 32'h0000_0024, 1'b0, 32'h0, 1, 1'b0);
        repeat (3) @(negedge clk);
        check_value("rst_both_req", {30'b0, m_cyc[1], m_cyc[0]}, 32'd3);
        check_value("rst_cyc", {31'b0, mem_cyc_o}, 32'd0);
        check_value("rst_stb", {31'b0, mem_stb_o}, 32'd0);
        check_value("rst_adr", mem_adr_o, 32'd0);
        check_value("rst_grant", {30'b0, o_grant}, 32'd0);
        reset = 1'b1;
        wait_idle(200);
        check_glog("rr_seq", 16'h0066, 5);

        // IF-only read with a 3-cycle slave.
        slave_delay = 3;
        push_job(0, 32'h0000_0100, 1'b0, 32'h0, 1, 1'b0);
        n = 0;
        while (!m_cyc[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("if_req_seen", {31'b0, m_cyc[0]}, 32'd1);
        check_value("if_grant_lat0", {30'b0, o_grant}, 32'd0);
        @(negedge clk);
        check_value("if_grant_lat1", {30'b0, o_grant}, 32'd1);
        check_value("if_mem_adr", mem_adr_o, 32'h0000_0100);
        check_value("if_mem_stb", {31'b0, mem_stb_o}, 32'd1);
        wait_idle(200);
        check_glog("if_only", 16'h0001, 2);

        // LSU locks the bus for a 4-beat write while IF waits.
        slave_delay = 1;
        push_job(1, 32'h0000_2000, 1'b1, 32'hA000_0000, 4, 1'b0);
        push_job(0, 32'h0000_0300, 1'b0, 32'h0, 1, 1'b0);
        wait_idle(300);
        check_glog("lock_seq", 16'h0006, 3);

        // Watchdog on a silent slave, then a normal retry.
        slave_mute = 1'b1;
        push_job(0, 32'h0000_0400, 1'b0, 32'h0, 1, 1'b1);
        stb_cnt = 0;
        found   = 1'b0;
        n       = 0;
        while (!found && n < 60) begin
            @(negedge clk);
            n++;
            if (if_err_o) begin
                found = 1'b1;
                check_value("wd_stb_forced", {31'b0, mem_stb_o}, 32'd0);
            end else if (mem_stb_o) begin
                stb_cnt++;
            end
        end
        check_value("wd_fired", {31'b0, found}, 32'd1);
        check_value("wd_stb_cycles", 32'(stb_cnt), 32'd8);
        wait_idle(100);
        slave_mute  = 1'b0;
        slave_delay = 0;
        push_job(0, 32'h0000_0400, 1'b0, 32'h0, 1, 1'b0);
        wait_idle(100);
        check_glog("wd_seq", 16'h0011, 4);

        // Async reset while the slave acks an LSU write.
        slave_delay = 2;
        push_job(1, 32'h0000_5000, 1'b1, 32'h5555_AAAA, 1, 1'b0);
        found = 1'b0;
        n     = 0;
        while (!found && n < 40) begin
            @(posedge clk);
            #3;
            n++;
            if (mem_ack_i && o_grant == 2'b10) found = 1'b1;
        end
        check_value("rst6_ack_seen", {31'b0, found}, 32'd1);
        reset = 1'b0;
        #1;
        check_value("rst6_cyc", {31'b0, mem_cyc_o}, 32'd0);
        check_value("rst6_stb", {31'b0, mem_stb_o}, 32'd0);
        check_value("rst6_dat", mem_dat_o, 32'd0);
        check_value("rst6_lsu_ack", {31'b0, lsu_ack_o}, 32'd0);
        check_value("rst6_grant", {30'b0, o_grant}, 32'd0);
        abort_req[1] = 1'b1;
        expq[1].delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_value("rst6_idle", {30'b0, o_grant}, 32'd0);
        check_value("rst6_cyc_after", {31'b0, mem_cyc_o}, 32'd0);
        check_value("sb_drained", 32'(expq[0].size() + expq[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
